// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Brief    : Instruction handshake, host register-file access and ALU port
//            bundle shared by alu_sequencer and its host/ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [2:0] alu_opcode;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_ac;
    logic       alu_z;
    logic       alu_s;
    logic [3:0] flags;
    logic       busy;
    logic       done;

    modport slave (
        input  instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
               alu_res, alu_c, alu_ac, alu_z, alu_s,
        output instr_ready, rd_data, alu_opcode, alu_op1, alu_op2,
               flags, busy, done
    );

    modport master (
        output instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
               alu_res, alu_c, alu_ac, alu_z, alu_s,
        input  instr_ready, rd_data, alu_opcode, alu_op1, alu_op2,
               flags, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : 4x8 register file driving a shared 8-bit ALU through an
//            IDLE/EXEC/WB sequence; define ALU_SEQ_PERF_EN for retired_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]    retired_cnt
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_rf [0:3];
    logic [2:0] r_opcode;
    logic [1:0] r_dst;
    logic [7:0] r_op1;
    logic [7:0] r_op2;
    logic [7:0] r_res;
    logic [3:0] r_flags_q;
    logic [3:0] r_flags;
    logic       w_ready;
    logic       w_accept;
    logic       w_load;
    logic       w_capture;
    logic       w_commit;

    // Host load wins over instruction acceptance, and only in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_ready = !bus.ld_en;
                w_load  = bus.ld_en;
                if (bus.instr_valid && !bus.ld_en) begin
                    w_accept     = 1'b1;
                    w_state_next = c_EXEC;
                end
            end
            c_EXEC: begin
                w_capture    = 1'b1;
                w_state_next = c_WB;
            end
            c_WB: begin
                w_commit     = 1'b1;
                w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_opcode  <= '0;
            r_dst     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_res     <= '0;
            r_flags_q <= '0;
            r_flags   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            // Operands are snapshotted here and held until the next acceptance.
            if (w_accept) begin
                r_opcode <= bus.instr[8:6];
                r_dst    <= bus.instr[5:4];
                r_op1    <= r_rf[bus.instr[3:2]];
                r_op2    <= r_rf[bus.instr[1:0]];
            end
            if (w_capture) begin
                r_res     <= bus.alu_res;
                r_flags_q <= {bus.alu_c, bus.alu_ac, bus.alu_z, bus.alu_s};
            end
            if (w_commit) begin
                r_rf[r_dst] <= r_res;
                r_flags     <= r_flags_q;
            end
            if (w_load) begin
                r_rf[bus.ld_addr] <= bus.ld_data;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.rd_data     = r_rf[bus.rd_addr];
    assign bus.alu_opcode  = r_opcode;
    assign bus.alu_op1     = r_op1;
    assign bus.alu_op2     = r_op2;
    assign bus.flags       = r_flags;
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = (r_state == c_WB);

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_commit && (r_retired != 16'hFFFF)) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired_cnt = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a behavioural ALU and
//            a scoreboard of expected write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] retired_cnt;
`endif

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef ALU_SEQ_PERF_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    // Behavioural ALU: returns {C, AC, Z, S, res}.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] r;
        logic       ac;
        logic [4:0] n;
        ac = 1'b0;
        case (op)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: begin
                r  = {1'b0, a} + {1'b0, b};
                n  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                ac = n[4];
            end
            3'd3: begin
                r  = {1'b0, a} - {1'b0, b};
                ac = (a[3:0] < b[3:0]);
            end
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {1'b0, a} + 9'd1;
            default: r = {a[0], 1'b0, a[7:1]};
        endcase
        return {r[8], ac, (r[7:0] == 8'h00), r[7], r[7:0]};
    endfunction

    assign {bus.alu_c, bus.alu_ac, bus.alu_z, bus.alu_s, bus.alu_res} =
        alu_ref(bus.alu_opcode, bus.alu_op1, bus.alu_op2);

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_rf [4];
    logic [3:0] m_flags;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_load(input logic [1:0] addr, input logic [7:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        tick();
        bus.ld_en   = 1'b0;
        m_rf[addr]  = data;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [1:0] dst,
                            input logic [1:0] s1, input logic [1:0] s2);
        exp_t e;
        e.op  = op;
        e.dst = dst;
        e.a   = m_rf[s1];
        e.b   = m_rf[s2];
        {e.flg, e.res} = alu_ref(op, e.a, e.b);
        sb.push_back(e);
    endtask

    // Offers an instruction, returns at the sample point just after acceptance.
    task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] s1, input logic [1:0] s2);
        int   k;
        exp_t e;
        bus.instr_valid = 1'b1;
        bus.instr       = {op, dst, s1, s2};
        #1;
        k = 0;
        while (!bus.instr_ready && k < 10) begin
            tick();
            k++;
        end
        if (!bus.instr_ready) begin
            n_checks++;
            $display("FAIL issue_ready_timeout: instr_ready=%b required 1", bus.instr_ready);
        end
        push_exp(op, dst, s1, s2);
        tick();
        bus.instr_valid = 1'b0;
        e = sb[$];
        n_checks++;
        if ({bus.busy, bus.alu_opcode, bus.alu_op1, bus.alu_op2} !== {1'b1, e.op, e.a, e.b})
            $display("FAIL exec_operands: busy/op/op1/op2=%b/%h/%h/%h required 1/%h/%h/%h",
                     bus.busy, bus.alu_opcode, bus.alu_op1, bus.alu_op2, e.op, e.a, e.b);
        else n_pass++;
    endtask

    // Waits for done, then checks the committed result against the scoreboard.
    task automatic wait_commit(output int lat);
        exp_t e;
        lat = 0;
        while (!bus.done && lat < 8) begin
            tick();
            lat++;
        end
        n_checks++;
        if (!bus.done || sb.size() == 0) begin
            $display("FAIL done_timeout: done=%b queue=%0d required done=1", bus.done, sb.size());
        end else begin
            bus.rd_addr = sb[0].dst;
            tick();
            e = sb.pop_front();
            m_rf[e.dst] = e.res;
            m_flags     = e.flg;
            if ({bus.rd_data, bus.flags, bus.done, bus.alu_opcode} !== {e.res, e.flg, 1'b0, e.op})
                $display("FAIL commit: rd/flags/done/op=%h/%b/%b/%h required %h/%b/0/%h",
                         bus.rd_data, bus.flags, bus.done, bus.alu_opcode, e.res, e.flg, e.op);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_en       = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.rd_addr     = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;
        n_checks++;
        if ({bus.busy, bus.instr_ready, bus.done, bus.flags} !== {1'b0, 1'b1, 1'b0, 4'h0})
            $display("FAIL reset_ctrl: busy/ready/done/flags=%b/%b/%b/%b required 0/1/0/0000",
                     bus.busy, bus.instr_ready, bus.done, bus.flags);
        else n_pass++;
        n_checks++;
        if ({bus.alu_opcode, bus.alu_op1, bus.alu_op2} !== 19'h0)
            $display("FAIL reset_alu: op/op1/op2=%h/%h/%h required 0/00/00",
                     bus.alu_opcode, bus.alu_op1, bus.alu_op2);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i);
            #1;
            n_checks++;
            if (bus.rd_data !== 8'h00)
                $display("FAIL reset_rf: rf[%0d]=%h required 00", i, bus.rd_data);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int lat;
        host_load(2'd0, 8'hF8);
        host_load(2'd1, 8'h08);
        issue(3'd2, 2'd2, 2'd0, 2'd1);
        n_checks++;
        if ({bus.alu_opcode, bus.alu_op1, bus.alu_op2} !== {3'd2, 8'hF8, 8'h08})
            $display("FAIL basic_exec: op/op1/op2=%h/%h/%h required 2/f8/08",
                     bus.alu_opcode, bus.alu_op1, bus.alu_op2);
        else n_pass++;
        wait_commit(lat);
        n_checks++;
        if (lat !== 1)
            $display("FAIL basic_latency: done after %0d cycles required 2", lat + 1);
        else n_pass++;
        n_checks++;
        if (bus.flags !== 4'b1110)
            $display("FAIL basic_flags: flags=%b required 1110", bus.flags);
        else n_pass++;
    endtask

    task automatic test_all_opcodes();
        int lat;
        for (int op = 0; op < 8; op++) begin
            host_load(2'd0, 8'($urandom));
            host_load(2'd1, 8'($urandom));
            issue(3'(op), 2'(op), 2'd0, 2'(op + 1));
            wait_commit(lat);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        host_load(2'd0, 8'h3C);
        host_load(2'd1, 8'h45);
        issue(3'd2, 2'd2, 2'd0, 2'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = {3'd3, 2'd3, 2'd2, 2'd1};
        bus.rd_addr     = 2'd2;
        tick();
        n_checks++;
        if ({bus.done, bus.instr_ready} !== 2'b10)
            $display("FAIL b2b_wb: done/ready=%b/%b required 1/0", bus.done, bus.instr_ready);
        else n_pass++;
        tick();
        e = sb.pop_front();
        m_rf[e.dst] = e.res;
        m_flags     = e.flg;
        n_checks++;
        if ({bus.rd_data, bus.flags, bus.instr_ready} !== {e.res, e.flg, 1'b1})
            $display("FAIL b2b_first: rd/flags/ready=%h/%b/%b required %h/%b/1",
                     bus.rd_data, bus.flags, bus.instr_ready, e.res, e.flg);
        else n_pass++;
        push_exp(3'd3, 2'd3, 2'd2, 2'd1);
        tick();
        bus.instr_valid = 1'b0;
        n_checks++;
        if ({bus.busy, bus.alu_op1} !== {1'b1, m_rf[2]})
            $display("FAIL b2b_dep: busy/op1=%b/%h required 1/%h", bus.busy, bus.alu_op1, m_rf[2]);
        else n_pass++;
        wait_commit(lat);
    endtask

    task automatic test_load_priority();
        int lat;
        bus.ld_en       = 1'b1;
        bus.ld_addr     = 2'd3;
        bus.ld_data     = 8'hA5;
        bus.instr_valid = 1'b1;
        bus.instr       = {3'd4, 2'd0, 2'd3, 2'd1};
        #1;
        n_checks++;
        if (bus.instr_ready !== 1'b0)
            $display("FAIL ld_prio_ready: instr_ready=%b required 0", bus.instr_ready);
        else n_pass++;
        tick();
        bus.ld_en = 1'b0;
        m_rf[3]   = 8'hA5;
        n_checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL ld_prio_accept: busy=%b required 0", bus.busy);
        else n_pass++;
        issue(3'd4, 2'd0, 2'd3, 2'd1);
        n_checks++;
        if (bus.alu_op1 !== 8'hA5)
            $display("FAIL ld_prio_op1: op1=%h required a5", bus.alu_op1);
        else n_pass++;
        wait_commit(lat);

        issue(3'd1, 2'd2, 2'd0, 2'd3);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 2'd3;
        bus.ld_data = 8'h55;
        wait_commit(lat);
        bus.ld_en   = 1'b0;
        bus.rd_addr = 2'd3;
        #1;
        n_checks++;
        if (bus.rd_data !== m_rf[3])
            $display("FAIL ld_ignored: rf[3]=%h required %h", bus.rd_data, m_rf[3]);
        else n_pass++;
    endtask

    task automatic test_reset_exec();
        host_load(2'd1, 8'h33);
        issue(3'd3, 2'd1, 2'd0, 2'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;
        n_checks++;
        if ({bus.busy, bus.done, bus.instr_ready, bus.alu_opcode} !== {1'b0, 1'b0, 1'b1, 3'd0})
            $display("FAIL rst_exec_state: busy/done/ready/op=%b/%b/%b/%h required 0/0/1/0",
                     bus.busy, bus.done, bus.instr_ready, bus.alu_opcode);
        else n_pass++;
        bus.rd_addr = 2'd1;
        tick();
        n_checks++;
        if ({bus.done, bus.rd_data, bus.flags} !== {1'b0, 8'h00, 4'h0})
            $display("FAIL rst_exec_nowb: done/rf1/flags=%b/%h/%b required 0/00/0000",
                     bus.done, bus.rd_data, bus.flags);
        else n_pass++;
    endtask

`ifdef ALU_SEQ_PERF_EN
    task automatic test_perf();
        int lat;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            host_load(2'd0, 8'(i * 17 + 3));
            issue(3'd2, 2'd1, 2'd0, 2'd1);
            wait_commit(lat);
        end
        n_checks++;
        if (retired_cnt !== 16'd5)
            $display("FAIL perf_count: retired_cnt=%0d required 5", retired_cnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (retired_cnt !== 16'd0)
            $display("FAIL perf_reset: retired_cnt=%0d required 0", retired_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_all_opcodes();
        test_back_to_back();
        test_load_priority();
        test_reset_exec();
`ifdef ALU_SEQ_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
